// File: rtl/cache_ctrl_nway_pkg.sv
// Shared definitions for the N-way cache controller: controller states and
// address-field width helpers derived from the block parameters.
package cache_ctrl_nway_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL
  } state_t;

  function automatic int unsigned bo_bits(input int unsigned wrd_width);
    return $clog2(wrd_width / 8);
  endfunction

  function automatic int unsigned wo_bits(input int unsigned blk_words);
    return $clog2(blk_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned nsets);
    return $clog2(nsets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned pa_width,
                                           input int unsigned wrd_width,
                                           input int unsigned blk_words,
                                           input int unsigned nsets);
    return pa_width - bo_bits(wrd_width) - wo_bits(blk_words) - idx_bits(nsets);
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_lru.sv
// True-LRU age store: per-set age counters, LRU way lookup and update on hit.
// Ages form a permutation of 0..NWAYS-1; age NWAYS-1 is least recently used.
module lru_nway #(
  parameter int unsigned NWAYS = 4,
  parameter int unsigned NSETS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NSETS)-1:0] set_idx,
  input  logic                     hit,
  input  logic [$clog2(NWAYS)-1:0] hit_way,
  output logic [$clog2(NWAYS)-1:0] lru_way
);

  localparam int unsigned AW = $clog2(NWAYS);

  logic [AW-1:0] age [NSETS][NWAYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NSETS; s++)
        for (int unsigned w = 0; w < NWAYS; w++)
          age[s][w] <= AW'(w);
    end else if (hit) begin
      for (int unsigned w = 0; w < NWAYS; w++) begin
        if (AW'(w) == hit_way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < age[set_idx][hit_way])
          age[set_idx][w] <= age[set_idx][w] + AW'(1);
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int unsigned w = 0; w < NWAYS; w++)
      if (age[set_idx][w] == AW'(NWAYS - 1))
        lru_way = AW'(w);
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back, write-allocate cache controller with
// tag/valid/dirty/data storage and a block-wide req/ack memory port.
module cache_ctrl_nway
  import cache_ctrl_nway_pkg::*;
#(
  parameter int unsigned NWAYS     = 4,
  parameter int unsigned NSETS     = 16,
  parameter int unsigned BLK_WORDS = 4,
  parameter int unsigned WRD_WIDTH = 32,
  parameter int unsigned PA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [PA_WIDTH-1:0]            cpu_addr,
  input  logic [WRD_WIDTH-1:0]           cpu_wdata,
  input  logic [WRD_WIDTH/8-1:0]         cpu_be,
  output logic                           cpu_ready,
  output logic                           cpu_done,
  output logic [WRD_WIDTH-1:0]           cpu_rdata,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [PA_WIDTH-1:0]            mem_addr,
  output logic [BLK_WORDS*WRD_WIDTH-1:0] mem_wdata,
  input  logic [BLK_WORDS*WRD_WIDTH-1:0] mem_rdata,
  input  logic                           mem_ack
);

  localparam int unsigned BO  = bo_bits(WRD_WIDTH);
  localparam int unsigned WO  = wo_bits(BLK_WORDS);
  localparam int unsigned IDX = idx_bits(NSETS);
  localparam int unsigned TAG = tag_bits(PA_WIDTH, WRD_WIDTH, BLK_WORDS, NSETS);
  localparam int unsigned NB  = WRD_WIDTH / 8;
  localparam int unsigned BLK = BLK_WORDS * WRD_WIDTH;
  localparam int unsigned WW  = $clog2(NWAYS);

  state_t               state;
  logic                 req_we;
  logic [TAG-1:0]       req_tag;
  logic [IDX-1:0]       req_idx;
  logic [WO-1:0]        req_wrd;
  logic [WRD_WIDTH-1:0] req_wdata;
  logic [NB-1:0]        req_be;
  logic [WW-1:0]        victim_q;

  logic [NSETS-1:0] valid [NWAYS];
  logic [NSETS-1:0] dirty [NWAYS];
  logic [TAG-1:0]   tags  [NWAYS][NSETS];
  logic [BLK-1:0]   data  [NWAYS][NSETS];

  logic                hit;
  logic [WW-1:0]       hit_way;
  logic [WW-1:0]       victim;
  logic [WW-1:0]       lru_way;
  logic                free_found;
  logic [BLK-1:0]      hit_line;
  logic [BLK-1:0]      merged_line;
  logic [PA_WIDTH-1:0] wb_addr;
  logic [PA_WIDTH-1:0] rf_addr;
  logic                addr_unused;

  assign addr_unused = ^cpu_addr[BO-1:0];

  // Lowest matching way wins should duplicate tags ever appear in a set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!hit && valid[w][req_idx] && (tags[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    hit_line = data[hit_way][req_idx];
  end

  always_comb begin
    free_found = 1'b0;
    victim     = lru_way;
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!free_found && !valid[w][req_idx]) begin
        free_found = 1'b1;
        victim     = WW'(w);
      end
    end
  end

  always_comb begin
    merged_line = hit_line;
    for (int unsigned b = 0; b < NB; b++)
      if (req_be[b])
        merged_line[req_wrd*WRD_WIDTH + b*8 +: 8] = req_wdata[b*8 +: 8];
  end

  assign wb_addr   = {tags[victim][req_idx], req_idx, {(BO+WO){1'b0}}};
  assign rf_addr   = {req_tag, req_idx, {(BO+WO){1'b0}}};
  assign cpu_ready = (state == IDLE);
  assign cpu_done  = (state == LOOKUP) && hit;

  always_comb begin
    cpu_rdata = '0;
    if (cpu_done)
      cpu_rdata = hit_line[req_wrd*WRD_WIDTH +: WRD_WIDTH];
  end

  lru_nway #(
    .NWAYS(NWAYS),
    .NSETS(NSETS)
  ) u_lru (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_idx(req_idx),
    .hit    (cpu_done),
    .hit_way(hit_way),
    .lru_way(lru_way)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_wrd   <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      victim_q  <= '0;
      for (int unsigned w = 0; w < NWAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_addr[PA_WIDTH-1 -: TAG];
            req_idx   <= cpu_addr[BO+WO +: IDX];
            req_wrd   <= cpu_addr[BO +: WO];
            req_wdata <= cpu_wdata;
            req_be    <= cpu_be;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we)
              dirty[hit_way][req_idx] <= 1'b1;
            state <= IDLE;
          end else begin
            victim_q <= victim;
            mem_req  <= 1'b1;
            if (valid[victim][req_idx] && dirty[victim][req_idx]) begin
              mem_we    <= 1'b1;
              mem_addr  <= wb_addr;
              mem_wdata <= data[victim][req_idx];
              state     <= WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= rf_addr;
              state    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            dirty[victim_q][req_idx] <= 1'b0;
            mem_we                   <= 1'b0;
            mem_addr                 <= rf_addr;
            state                    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid[victim_q][req_idx] <= 1'b1;
            dirty[victim_q][req_idx] <= 1'b0;
            mem_req                  <= 1'b0;
            state                    <= LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && mem_ack) begin
      data[victim_q][req_idx] <= mem_rdata;
      tags[victim_q][req_idx] <= req_tag;
    end else if (cpu_done && req_we) begin
      data[hit_way][req_idx] <= merged_line;
    end
  end

endmodule
